smg_scan_ctrl: RTL
==================

# smg_scan_ctrl

Seven-segment scan controller for the temperature display. It time-multiplexes a DIGITS-wide common-anode display from the 50 MHz system clock, with a blanking interval at the start of every digit slot to suppress ghosting. The temperature datapath hands it BCD frames through a valid/ready handshake. Frames are double-buffered and swapped only at frame boundaries, so the display never shows a torn value.

## Interface
- DIGITS, 4: number of digits; legal range 2..8.
- TICK_DIV, 25000: clk_50MHz cycles per digit slot (500 µs per slot at the default).
- BLANK_CYC, 50: cycles at the start of each slot with all digits off; must satisfy 1 ≤ BLANK_CYC < TICK_DIV.
- clk_50MHz  input  1  system clock; the only clock.
- rst  input  1  reset; asynchronous, active-low.
- upd_valid  input  1  a new frame is presented.
- upd_ready  output  1  shadow buffer is empty; the frame is accepted on the edge where valid && ready.
- upd_bcd  input  4*DIGITS  BCD digits; nibble [3:0] is digit 0 (rightmost).
- upd_dp  input  DIGITS  decimal point enable per digit.
- upd_neg  input  1  negative value; the leftmost digit shows '-'.
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
- sel  output  DIGITS  active-low digit enables; sel[i] drives digit i.
- frame_done  output  1  one-cycle pulse at each frame boundary.

## Operation
- Buffers
  - Shadow {bcd, dp, neg, full}: loaded on accept; full is set on the same edge.
  - Active {bcd, dp, neg}: drives the display.
  - upd_ready = !full.
- Frame boundary is the edge where slot_cnt == TICK_DIV-1 and digit == DIGITS-1.
  - If full: active <= shadow and full <= 0.
  - frame_done <= 1 for one cycle.
- Accept and boundary on the same edge: ready was high, so shadow was empty. The new frame goes to shadow and reaches active at the next boundary. There is no bypass.
- Counters
  - slot_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - On wrap, digit increments 0..DIGITS-1 and wraps to 0.
  - Scan order is digit 0 first.
- State machine (per slot)
  - BLANK: slot_cnt < BLANK_CYC. Registered outputs are sel = all ones, seg = 8'hFF.
  - DRIVE: BLANK_CYC ≤ slot_cnt ≤ TICK_DIV-1. sel has only bit [digit] low; seg = glyph(digit).
  - BLANK→DRIVE when slot_cnt reaches BLANK_CYC-1.
  - DRIVE→BLANK on slot wrap.
- Glyph selection for digit i, in priority order:
  1. i == DIGITS-1 and neg: '-' = 8'hBF, with the dp bit applied. The nibble is ignored.
  2. Leading-zero suppression: blank (8'hFF) if i ≥ 1, nibble == 0, dp[i] == 0, and every more-significant digit is also suppressed or is the sign position. Digit 0 is never suppressed.
  3. Nibble 0..9 → C0,F9,A4,B0,99,92,82,F8,80,90.
  4. Nibble 10..15: blank, FF.
- Decimal point: if dp[i], seg[7] is forced to 0, including on blank glyphs.
- Reset (asserted, asynchronous):
  - slot_cnt = 0, digit = 0, state BLANK.
  - Active buffer = 0 (bcd 0, dp 0, neg 0); shadow cleared, full = 0.
  - seg = 8'hFF, sel = all ones, upd_ready = 1, frame_done = 0.
  - A shadow frame pending when reset asserts is discarded.

## Timing
- seg, sel and frame_done are registered. They reflect the slot_cnt/digit values from one cycle earlier.
- After reset release, slot_cnt = 0 on the first edge. The first DRIVE output (digit 0) appears at cycle BLANK_CYC+1.
- Frame period is DIGITS*TICK_DIV cycles. frame_done is high for exactly one cycle per frame.
- Accept-to-display latency: from 1 cycle up to DIGITS*TICK_DIV cycles to the next boundary, then +1 cycle for the registered output.
- upd_ready falls on the edge after accept. It rises on the edge after the boundary that empties the shadow.
- Upstream must hold upd_* stable while valid && !ready. Dropping valid before acceptance drops the frame. This is legal.
- The same cycle carries the active swap and the frame_done pulse. The first slot of the new frame uses the new active buffer.

## Test plan
Simulation parameters: DIGITS=4, TICK_DIV=20, BLANK_CYC=4.
1. Reset, then run.
   - During reset: seg=FF, sel=F, upd_ready=1.
   - In digit-0 DRIVE: sel=E, seg=C0.
   - Digits 1..3: seg=FF.
   - frame_done period = 80 cycles.
2. Load bcd=0x0235, dp=4'b0010, neg=0. After the next frame_done:
   - d0 = 92.
   - d1 = 30 (3 with dp).
   - d2 = A4.
   - d3 = FF (suppressed).
3. Load bcd=0x0125, neg=1, dp=4'b0010:
   - d3 = BF.
   - d2 = F9.
   - d1 = 24.
   - d0 = 92.
4. Backpressure.
   - Send A=0x1111, then immediately B=0x2222.
   - upd_ready stays 0 until A's boundary.
   - A is displayed for one frame, then B.
   - No frame is lost; upd_ready = 1 after B swaps.
5. Blanking.
   - In every slot, sel = F for exactly 4 cycles, then one low bit for 16 cycles.
   - Never more than one sel bit is low.
   - Nibble 0xC on d0 gives seg = FF during DRIVE.
6. Reset mid-DRIVE with the shadow full.
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - After release, the display shows "   0".
   - The pending frame is not displayed.

Source files
------------

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: seven-segment scan controller with blanking and double-buffered BCD frames
// Ports: clk_50MHz system clock; rst async active-low reset;
//   upd_valid/upd_ready/upd_bcd/upd_dp/upd_neg frame handshake into the shadow buffer;
//   seg active-low {dp,g,f,e,d,c,b,a}; sel active-low digit enables; frame_done boundary pulse.
module smg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 25000,
  parameter int BLANK_CYC = 50
) (
  input  logic                  clk_50MHz,
  input  logic                  rst,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [4*DIGITS-1:0]   upd_bcd,
  input  logic [DIGITS-1:0]     upd_dp,
  input  logic                  upd_neg,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);
  localparam int SW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DIGITS);
  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t              state_q, state_d;
  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [4*DIGITS-1:0] sh_bcd_q, sh_bcd_d, act_bcd_q, act_bcd_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                sh_neg_q, sh_neg_d, act_neg_q, act_neg_d;
  logic                full_q, full_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_done_q, frame_done_d;
  logic                slot_wrap, boundary, accept, sup;
  logic [3:0]          nib;
  logic [7:0]          glyph;
  int                  di;
  assign di        = int'(digit_q);
  assign upd_ready = !full_q;
  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q      <= BLANK;
      slot_cnt_q   <= '0;
      digit_q      <= '0;
      sh_bcd_q     <= '0;
      sh_dp_q      <= '0;
      sh_neg_q     <= 1'b0;
      full_q       <= 1'b0;
      act_bcd_q    <= '0;
      act_dp_q     <= '0;
      act_neg_q    <= 1'b0;
      seg_q        <= 8'hFF;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      digit_q      <= digit_d;
      sh_bcd_q     <= sh_bcd_d;
      sh_dp_q      <= sh_dp_d;
      sh_neg_q     <= sh_neg_d;
      full_q       <= full_d;
      act_bcd_q    <= act_bcd_d;
      act_dp_q     <= act_dp_d;
      act_neg_q    <= act_neg_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end
  always_comb begin
    slot_wrap    = slot_cnt_q == SW'(TICK_DIV-1);
    boundary     = slot_wrap && digit_q == DW'(DIGITS-1);
    accept       = upd_valid && !full_q;
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + SW'(1);
    digit_d      = !slot_wrap ? digit_q : (digit_q == DW'(DIGITS-1)) ? '0 : digit_q + DW'(1);
    sh_bcd_d     = accept ? upd_bcd : sh_bcd_q;
    sh_dp_d      = accept ? upd_dp : sh_dp_q;
    sh_neg_d     = accept ? upd_neg : sh_neg_q;
    // accept and boundary can coincide only with an empty shadow, so no bypass to active
    full_d       = accept || (full_q && !boundary);
    act_bcd_d    = (boundary && full_q) ? sh_bcd_q : act_bcd_q;
    act_dp_d     = (boundary && full_q) ? sh_dp_q : act_dp_q;
    act_neg_d    = (boundary && full_q) ? sh_neg_q : act_neg_q;
    frame_done_d = boundary;
  end
  always_comb begin
    state_d = (state_q == BLANK && slot_cnt_q == SW'(BLANK_CYC-1)) ? DRIVE :
              (state_q == DRIVE && slot_wrap) ? BLANK : state_q;
  end
  always_comb begin
    nib = act_bcd_q[4*di +: 4];
    // a digit is suppressed when it and every higher digit is a plain zero or the sign slot
    sup = di != 0;
    for (int j = 1; j < DIGITS; j++)
      if (j >= di && !((act_bcd_q[4*j +: 4] == 4'd0 && !act_dp_q[j]) || (j == DIGITS-1 && act_neg_q)))
        sup = 1'b0;
    glyph = (di == DIGITS-1 && act_neg_q) ? 8'hBF : sup ? 8'hFF : GLYPH[nib];
    seg_d = (state_q == DRIVE) ? {glyph[7] & ~act_dp_q[di], glyph[6:0]} : 8'hFF;
    sel_d = (state_q == DRIVE) ? ~(DIGITS'(1) << digit_q) : '1;
  end
endmodule
